// File: rtl/clock_enable_gen.sv
// Multi-channel clock divider: 50% square wave plus one-cycle rising-edge tick per channel,
// runtime divisor updates through a single pending slot, global sync phase alignment.
module clock_enable_gen #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 27,
   parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT =
      {27'd99999, 27'd9999999, 27'd24999999, 27'd49999999}
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic              sync,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [2:0]        cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   output logic              cfg_err,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick
);

   logic              pend_valid;
   logic [2:0]        pend_ch;
   logic [CNT_W-1:0]  pend_div;
   logic [NUM_CH-1:0] apply;
   logic              accept;
   logic              ch_ok;

   assign accept    = cfg_valid && cfg_ready;
   assign ch_ok     = ({1'b0, cfg_ch} < 4'(NUM_CH));
   assign cfg_ready = !pend_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_valid <= 1'b0;
         pend_ch    <= '0;
         pend_div   <= '0;
         cfg_err    <= 1'b0;
      end else begin
         cfg_err <= accept && !ch_ok;
         if (|apply) begin
            pend_valid <= 1'b0;
         end else if (accept && ch_ok) begin
            pend_valid <= 1'b1;
            pend_ch    <= cfg_ch;
            pend_div   <= cfg_div;
         end
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] div;
      logic [CNT_W-1:0] div_nx;
      logic             lvl;
      logic             tk;
      logic             term;

      assign term = (cnt == div);
      // New divisor only lands where cnt is, or is about to be, zero: no runt pulse
      assign apply[i] = pend_valid && (pend_ch == 3'(i)) &&
                        (sync || !ch_en[i] || term);
      assign div_nx = apply[i] ? pend_div : div;

      always_ff @(posedge clk) begin
         if (rst) begin
            cnt <= '0;
            lvl <= 1'b0;
            tk  <= 1'b0;
            div <= DIV_INIT[i*CNT_W +: CNT_W];
         end else begin
            div <= div_nx;
            if (sync || !ch_en[i]) begin
               cnt <= '0;
               lvl <= 1'b0;
               tk  <= 1'b0;
            end else if (term) begin
               cnt <= '0;
               lvl <= ~lvl;
               tk  <= ~lvl;
            end else begin
               cnt <= cnt + CNT_W'(1);
               tk  <= 1'b0;
            end
         end
      end

      assign clk_out[i] = lvl;
      assign tick[i]    = tk;
   end

endmodule

// File: tb/tb_clock_enable_gen.sv
// Randomized bench for clock_enable_gen against a countdown-style reference model.
// Covers reset, divisor reconfig, sync, enable gating and invalid-channel requests.
module tb_clock_enable_gen;

   localparam int NUM_CH = 2;
   localparam int CNT_W  = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [NUM_CH-1:0] ch_en;
   logic              sync;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [2:0]        cfg_ch;
   logic [CNT_W-1:0]  cfg_div;
   logic              cfg_err;
   logic [NUM_CH-1:0] clk_out;
   logic [NUM_CH-1:0] tick;

   clock_enable_gen #(
      .NUM_CH   (NUM_CH),
      .CNT_W    (CNT_W),
      .DIV_INIT ({8'd1, 8'd3})
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ch_en     (ch_en),
      .sync      (sync),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .cfg_err   (cfg_err),
      .clk_out   (clk_out),
      .tick      (tick)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
   endtask

   // Model: cycles remaining until the next toggle, and the output level
   int m_rem [NUM_CH];
   int m_div [NUM_CH];
   bit m_lvl [NUM_CH];
   bit m_tk  [NUM_CH];
   bit m_pend;
   int m_pch;
   int m_pdiv;
   bit m_err;

   task automatic model_step();
      bit app [NUM_CH];
      bit new_err;
      int nd;
      if (rst) begin
         m_div[0] = 3;
         m_div[1] = 1;
         for (int i = 0; i < NUM_CH; i++) begin
            m_rem[i] = m_div[i] + 1;
            m_lvl[i] = 0;
            m_tk[i]  = 0;
         end
         m_pend = 0;
         m_err  = 0;
         return;
      end
      for (int i = 0; i < NUM_CH; i++)
         app[i] = m_pend && m_pch == i &&
                  (sync || !ch_en[i] || m_rem[i] == 1);
      new_err = cfg_valid && !m_pend && cfg_ch >= NUM_CH;
      for (int i = 0; i < NUM_CH; i++) begin
         nd = app[i] ? m_pdiv : m_div[i];
         if (sync || !ch_en[i]) begin
            m_lvl[i] = 0;
            m_tk[i]  = 0;
            m_rem[i] = nd + 1;
         end else if (m_rem[i] == 1) begin
            m_lvl[i] = !m_lvl[i];
            m_tk[i]  = m_lvl[i];
            m_rem[i] = nd + 1;
         end else begin
            m_rem[i]--;
            m_tk[i] = 0;
         end
         m_div[i] = nd;
      end
      if (app[0] || app[1]) m_pend = 0;
      else if (cfg_valid && !m_pend && cfg_ch < NUM_CH) begin
         m_pend = 1;
         m_pch  = int'(cfg_ch);
         m_pdiv = int'(cfg_div);
      end
      m_err = new_err;
   endtask

   initial begin
      int first_tick;
      rst       = 1'b1;
      ch_en     = '1;
      sync      = 1'b0;
      cfg_valid = 1'b0;
      cfg_ch    = '0;
      cfg_div   = '0;
      first_tick = -1;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if (c < 3) begin
            rst = 1'b1;
         end else if (c < 40) begin
            rst       = 1'b0;
            ch_en     = '1;
            sync      = 1'b0;
            cfg_valid = 1'b0;
         end else begin
            rst   = ($urandom_range(0, 299) == 0);
            ch_en = {($urandom_range(0, 9) != 0), ($urandom_range(0, 9) != 0)};
            sync  = ($urandom_range(0, 39) == 0);
            cfg_valid = ($urandom_range(0, 5) == 0);
            cfg_ch = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(2, 7))
                                                  : 3'($urandom_range(0, 1));
            cfg_div = 8'($urandom_range(0, 5));
         end
         @(posedge clk);
         model_step();
         #1;
         chk("clk_out", 32'(clk_out), {30'd0, m_lvl[1], m_lvl[0]});
         chk("tick", 32'(tick), {30'd0, m_tk[1], m_tk[0]});
         chk("cfg_ready", 32'(cfg_ready), 32'(!m_pend));
         chk("cfg_err", 32'(cfg_err), 32'(m_err));
         if (c >= 3 && c < 40 && first_tick < 0 && tick[0]) first_tick = c - 2;
      end
      // Reset released before the edge of c=3; first ch0 tick is 4 cycles later
      chk("first_tick0", 32'(first_tick), 32'd4);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
